// File: rtl/nvdla_dbb_burst_sched_pkg.sv
// Shared types for the DBB burst scheduler: FSM states, arbiter grant and beat geometry.
package nvdla_dbb_burst_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_REQ,
    W_DAT,
    W_RSP,
    W_DONE,
    R_REQ,
    R_DAT
  } state_dbb_sched_t;

  typedef enum logic {
    GNT_WR = 1'b0,
    GNT_RD = 1'b1
  } grant_t;

  localparam int unsigned DEF_DW     = 512;
  localparam int unsigned BEAT_BYTES = DEF_DW / 8;

endpackage

// File: rtl/nvdla_dbb_burst_sched_if.sv
// Upstream burst channels and downstream single-beat bridge channels of the scheduler.
interface nvdla_dbb_burst_sched_if #(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = 512,
  parameter int unsigned IDW = 8
);
  logic            wr_req_valid, wr_req_ready;
  logic [AW-1:0]   wr_req_addr;
  logic [7:0]      wr_req_len;
  logic [IDW-1:0]  wr_req_id;
  logic            wr_dat_valid, wr_dat_ready;
  logic [DW-1:0]   wr_dat;
  logic [DW/8-1:0] wr_strb;
  logic            wr_last;
  logic            wr_rsp_valid, wr_rsp_ready;
  logic [IDW-1:0]  wr_rsp_id;
  logic            rd_req_valid, rd_req_ready;
  logic [AW-1:0]   rd_req_addr;
  logic [7:0]      rd_req_len;
  logic [IDW-1:0]  rd_req_id;
  logic            rd_dat_valid, rd_dat_ready;
  logic [DW-1:0]   rd_dat;
  logic [IDW-1:0]  rd_id;
  logic            rd_last;

  logic            b_wreq_valid, b_wreq_ready;
  logic [AW-1:0]   b_wreq_addr;
  logic [IDW-1:0]  b_wreq_id;
  logic            b_wdat_valid, b_wdat_ready;
  logic [DW-1:0]   b_wdat;
  logic [DW/8-1:0] b_wstrb;
  logic            b_wrsp_valid, b_wrsp_ready;
  logic            b_rreq_valid, b_rreq_ready;
  logic [AW-1:0]   b_rreq_addr;
  logic [IDW-1:0]  b_rreq_id;
  logic            b_rdat_valid, b_rdat_ready;
  logic [DW-1:0]   b_rdat;

  // Scheduler side
  modport slave (
    input  wr_req_valid, wr_req_addr, wr_req_len, wr_req_id,
    output wr_req_ready,
    input  wr_dat_valid, wr_dat, wr_strb, wr_last,
    output wr_dat_ready,
    output wr_rsp_valid, wr_rsp_id,
    input  wr_rsp_ready,
    input  rd_req_valid, rd_req_addr, rd_req_len, rd_req_id,
    output rd_req_ready,
    output rd_dat_valid, rd_dat, rd_id, rd_last,
    input  rd_dat_ready,
    output b_wreq_valid, b_wreq_addr, b_wreq_id,
    input  b_wreq_ready,
    output b_wdat_valid, b_wdat, b_wstrb,
    input  b_wdat_ready,
    input  b_wrsp_valid,
    output b_wrsp_ready,
    output b_rreq_valid, b_rreq_addr, b_rreq_id,
    input  b_rreq_ready,
    input  b_rdat_valid, b_rdat,
    output b_rdat_ready
  );

  // Environment side: upstream master plus bridge
  modport master (
    output wr_req_valid, wr_req_addr, wr_req_len, wr_req_id,
    input  wr_req_ready,
    output wr_dat_valid, wr_dat, wr_strb, wr_last,
    input  wr_dat_ready,
    input  wr_rsp_valid, wr_rsp_id,
    output wr_rsp_ready,
    output rd_req_valid, rd_req_addr, rd_req_len, rd_req_id,
    input  rd_req_ready,
    input  rd_dat_valid, rd_dat, rd_id, rd_last,
    output rd_dat_ready,
    input  b_wreq_valid, b_wreq_addr, b_wreq_id,
    output b_wreq_ready,
    input  b_wdat_valid, b_wdat, b_wstrb,
    output b_wdat_ready,
    output b_wrsp_valid,
    input  b_wrsp_ready,
    input  b_rreq_valid, b_rreq_addr, b_rreq_id,
    output b_rreq_ready,
    output b_rdat_valid, b_rdat,
    input  b_rdat_ready
  );
endinterface

// File: rtl/nvdla_dbb_rr_arb.sv
// Two-way read/write round-robin; the last-grant register moves only on an explicit update pulse.
module nvdla_dbb_rr_arb
  import nvdla_dbb_burst_sched_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   req_wr,
  input  logic   req_rd,
  input  logic   update,
  input  grant_t upd_gnt,
  output grant_t gnt
);
  grant_t last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= GNT_RD;
    end else if (update) begin
      last <= upd_gnt;
    end
  end

  always_comb begin
    gnt = GNT_WR;
    if (req_wr && req_rd) begin
      gnt = (last == GNT_RD) ? GNT_WR : GNT_RD;
    end else if (req_rd) begin
      gnt = GNT_RD;
    end
  end
endmodule

// File: rtl/nvdla_dbb_burst_sched.sv
// Splits upstream bursts into single-beat bridge transactions, one burst in flight,
// with read/write round-robin and a single write response per burst.
module nvdla_dbb_burst_sched
  import nvdla_dbb_burst_sched_pkg::*;
#(
  parameter int unsigned AW  = 32,
  parameter int unsigned DW  = DEF_DW,
  parameter int unsigned IDW = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  nvdla_dbb_burst_sched_if.slave bus,
  output logic                   err,
  output logic                   busy
);
  localparam logic [AW-1:0] BSTRIDE = AW'(DW / 8);

  state_dbb_sched_t state, state_nxt;
  logic [7:0]       beat_cnt, cnt_nxt, len, len_nxt;
  logic [AW-1:0]    base, base_nxt, beat_addr;
  logic [IDW-1:0]   id, id_nxt;
  logic             err_nxt, is_last, arb_upd;
  grant_t           gnt, upd_gnt;

  // Compared before incrementing so len=255 never wraps beat_cnt
  assign is_last   = (beat_cnt == len);
  assign beat_addr = base + AW'(beat_cnt) * BSTRIDE;
  assign busy      = (state != IDLE);

  assign bus.b_wreq_addr = beat_addr;
  assign bus.b_rreq_addr = beat_addr;
  assign bus.b_wreq_id   = id;
  assign bus.b_rreq_id   = id;
  assign bus.wr_rsp_id   = id;
  assign bus.rd_id       = id;
  assign bus.rd_dat      = bus.b_rdat;
  assign bus.b_wdat      = bus.wr_dat;
  assign bus.b_wstrb     = bus.wr_strb;

  nvdla_dbb_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_wr  (bus.wr_req_valid),
    .req_rd  (bus.rd_req_valid),
    .update  (arb_upd),
    .upd_gnt (upd_gnt),
    .gnt     (gnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat_cnt <= '0;
      base     <= '0;
      len      <= '0;
      id       <= '0;
      err      <= 1'b0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= cnt_nxt;
      base     <= base_nxt;
      len      <= len_nxt;
      id       <= id_nxt;
      err      <= err_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    cnt_nxt          = beat_cnt;
    base_nxt         = base;
    len_nxt          = len;
    id_nxt           = id;
    err_nxt          = err;
    arb_upd          = 1'b0;
    upd_gnt          = GNT_WR;
    bus.wr_req_ready = 1'b0;
    bus.rd_req_ready = 1'b0;
    bus.wr_dat_ready = 1'b0;
    bus.wr_rsp_valid = 1'b0;
    bus.rd_dat_valid = 1'b0;
    bus.rd_last      = 1'b0;
    bus.b_wreq_valid = 1'b0;
    bus.b_wdat_valid = 1'b0;
    bus.b_wrsp_ready = 1'b0;
    bus.b_rreq_valid = 1'b0;
    bus.b_rdat_ready = 1'b0;
    case (state)
      IDLE: begin
        if (bus.wr_req_valid || bus.rd_req_valid) begin
          cnt_nxt = '0;
          if (gnt == GNT_WR) begin
            bus.wr_req_ready = 1'b1;
            base_nxt         = bus.wr_req_addr;
            len_nxt          = bus.wr_req_len;
            id_nxt           = bus.wr_req_id;
            state_nxt        = W_REQ;
          end else begin
            bus.rd_req_ready = 1'b1;
            base_nxt         = bus.rd_req_addr;
            len_nxt          = bus.rd_req_len;
            id_nxt           = bus.rd_req_id;
            state_nxt        = R_REQ;
          end
        end
      end
      W_REQ: begin
        bus.b_wreq_valid = 1'b1;
        if (bus.b_wreq_ready) state_nxt = W_DAT;
      end
      W_DAT: begin
        bus.b_wdat_valid = bus.wr_dat_valid;
        bus.wr_dat_ready = bus.b_wdat_ready;
        if (bus.wr_dat_valid && bus.b_wdat_ready) begin
          // A misplaced last only flags the error; beat counting still follows len
          if (bus.wr_last != is_last) err_nxt = 1'b1;
          state_nxt = W_RSP;
        end
      end
      W_RSP: begin
        bus.b_wrsp_ready = 1'b1;
        if (bus.b_wrsp_valid) begin
          if (is_last) begin
            state_nxt = W_DONE;
          end else begin
            cnt_nxt   = beat_cnt + 8'd1;
            state_nxt = W_REQ;
          end
        end
      end
      W_DONE: begin
        bus.wr_rsp_valid = 1'b1;
        if (bus.wr_rsp_ready) begin
          arb_upd   = 1'b1;
          upd_gnt   = GNT_WR;
          state_nxt = IDLE;
        end
      end
      R_REQ: begin
        bus.b_rreq_valid = 1'b1;
        if (bus.b_rreq_ready) state_nxt = R_DAT;
      end
      R_DAT: begin
        bus.rd_dat_valid = bus.b_rdat_valid;
        bus.b_rdat_ready = bus.rd_dat_ready;
        bus.rd_last      = is_last;
        if (bus.b_rdat_valid && bus.rd_dat_ready) begin
          if (is_last) begin
            arb_upd   = 1'b1;
            upd_gnt   = GNT_RD;
            state_nxt = IDLE;
          end else begin
            cnt_nxt   = beat_cnt + 8'd1;
            state_nxt = R_REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule

// File: tb/tb_nvdla_dbb_burst_sched.sv
// Randomized bench for the DBB burst scheduler: upstream/bridge emulation plus a burst-level reference model.
module tb_nvdla_dbb_burst_sched;
  import nvdla_dbb_burst_sched_pkg::*;

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  id;
    bit          bad;
  } job_t;

  typedef struct {
    logic [511:0] data;
    logic [63:0]  strb;
    bit           last;
  } wbeat_t;

  logic clk, rst_n, err, busy;
  nvdla_dbb_burst_sched_if #(.AW(32), .DW(512), .IDW(8)) bus ();

  nvdla_dbb_burst_sched #(.AW(32), .DW(512), .IDW(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .err   (err),
    .busy  (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0, n_fail = 0;

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  job_t   wr_jobs[$], rd_jobs[$], cur;
  wbeat_t wbeats[$], exp_wb[$];
  logic [31:0] rq[$];
  bit     served[$];
  bit     in_flight, exp_err, last_wr, first_seen, rd_rand;
  bit     wdat_on, wrsp_on, rdat_on;
  int     nreq, ndat, nrsp, rbeat, wrsp_pend, stall_beat, stall_left, stall_seen;
  int unsigned cyc, acc_cyc, bw_cnt, br_cnt, wrsp_cnt, rbeat_cnt;

  function automatic logic [511:0] rd_pattern(input logic [31:0] a);
    logic [511:0] v;
    for (int unsigned k = 0; k < 16; k++)
      v[k*32 +: 32] = (a * 32'h9E37_79B1) ^ (32'(k) << 24) ^ 32'h005A_5A5A;
    return v;
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] base, input int beat);
    logic [31:0] a;
    a = base + 32'(beat) * 32'(BEAT_BYTES);
    return a;
  endfunction

  task automatic clear_model();
    wr_jobs.delete(); rd_jobs.delete(); wbeats.delete(); exp_wb.delete(); rq.delete();
    in_flight = 0; exp_err = 0; last_wr = 0; first_seen = 0;
    wdat_on = 0; wrsp_on = 0; rdat_on = 0;
    nreq = 0; ndat = 0; nrsp = 0; rbeat = 0; wrsp_pend = 0;
    stall_beat = -1; stall_left = 0;
  endtask

  task automatic idle_inputs();
    bus.wr_req_valid = 0; bus.wr_req_addr = '0; bus.wr_req_len = '0; bus.wr_req_id = '0;
    bus.rd_req_valid = 0; bus.rd_req_addr = '0; bus.rd_req_len = '0; bus.rd_req_id = '0;
    bus.wr_dat_valid = 0; bus.wr_dat = '0; bus.wr_strb = '0; bus.wr_last = 0;
    bus.wr_rsp_ready = 0; bus.rd_dat_ready = 0;
    bus.b_wreq_ready = 0; bus.b_wdat_ready = 0; bus.b_rreq_ready = 0;
    bus.b_wrsp_valid = 0; bus.b_rdat_valid = 0; bus.b_rdat = '0;
  endtask

  task automatic start_job(input job_t j);
    wbeat_t w;
    if (bus.wr_req_valid && bus.rd_req_valid) check("rr_pick", j.is_wr, !last_wr);
    cur = j; in_flight = 1; first_seen = 0; acc_cyc = cyc;
    nreq = 0; ndat = 0; nrsp = 0; rbeat = 0;
    served.push_back(j.is_wr);
    if (j.is_wr) begin
      for (int i = 0; i <= int'(j.len); i++) begin
        for (int unsigned k = 0; k < 16; k++) w.data[k*32 +: 32] = $urandom;
        w.strb = {$urandom, $urandom};
        w.last = (i == int'(j.len)) ^ (j.bad && i == 0);
        wbeats.push_back(w);
        exp_wb.push_back(w);
      end
    end
  endtask

  task automatic monitor();
    logic [31:0] ea;
    wbeat_t w;
    bit up_hs, b_hs;
    check("busy", busy, in_flight);
    check("err", err, exp_err);
    if (in_flight) begin
      check("req_rdy_busy", {bus.wr_req_ready, bus.rd_req_ready}, 2'b00);
      if ((bus.b_wreq_valid || bus.b_rreq_valid) && nreq == 0 && !first_seen) begin
        check("first_req_lat", cyc - acc_cyc, 1);
        first_seen = 1;
      end
    end else if (bus.wr_req_valid || bus.rd_req_valid) begin
      check("grant_one", {bus.wr_req_ready && bus.wr_req_valid, bus.rd_req_ready && bus.rd_req_valid} != 2'b00
                         && !(bus.wr_req_ready && bus.rd_req_ready), 1);
    end
    if (bus.wr_req_valid && bus.wr_req_ready && bus.rd_req_valid && bus.rd_req_ready)
      check("dual_accept", 1, 0);
    if (bus.wr_req_valid && bus.wr_req_ready && wr_jobs.size() > 0) start_job(wr_jobs.pop_front());
    else if (bus.rd_req_valid && bus.rd_req_ready && rd_jobs.size() > 0) start_job(rd_jobs.pop_front());
    else if (bus.wr_req_ready || bus.rd_req_ready) check("rdy_wo_valid", {bus.wr_req_valid, bus.rd_req_valid} != 0, 1);

    if (bus.b_wreq_valid && bus.b_wreq_ready) begin
      check("wreq_ctx", in_flight && cur.is_wr && nreq == nrsp, 1);
      ea = beat_addr(cur.addr, nreq);
      check("wreq_addr", bus.b_wreq_addr, ea);
      check("wreq_id", bus.b_wreq_id, cur.id);
      nreq++; bw_cnt++;
    end

    up_hs = bus.wr_dat_valid && bus.wr_dat_ready;
    b_hs  = bus.b_wdat_valid && bus.b_wdat_ready;
    check("wdat_hs_pair", b_hs, up_hs);
    if (b_hs) begin
      check("wdat_ctx", in_flight && cur.is_wr && ndat + 1 == nreq && exp_wb.size() > 0, 1);
      if (exp_wb.size() > 0) begin
        w = exp_wb.pop_front();
        check("wdat_data", bus.b_wdat, w.data);
        check("wdat_strb", bus.b_wstrb, w.strb);
        if (w.last != (ndat == int'(cur.len))) exp_err = 1;
      end
      ndat++; wrsp_pend++;
    end
    if (up_hs && wbeats.size() > 0) begin
      void'(wbeats.pop_front());
      wdat_on = 0;
    end

    if (bus.b_wrsp_valid && bus.b_wrsp_ready) begin
      check("bwrsp_ctx", in_flight && cur.is_wr && nrsp + 1 == ndat, 1);
      nrsp++; wrsp_pend--; wrsp_on = 0;
    end

    if (bus.wr_rsp_valid) begin
      check("wrsp_early", in_flight && cur.is_wr && nrsp == int'(cur.len) + 1, 1);
      check("wrsp_id", bus.wr_rsp_id, cur.id);
      if (bus.wr_rsp_ready) begin
        wrsp_cnt++; in_flight = 0; last_wr = 1;
      end
    end

    if (bus.b_rreq_valid && bus.b_rreq_ready) begin
      check("rreq_ctx", in_flight && !cur.is_wr && nreq == rbeat, 1);
      ea = beat_addr(cur.addr, nreq);
      check("rreq_addr", bus.b_rreq_addr, ea);
      check("rreq_id", bus.b_rreq_id, cur.id);
      rq.push_back(ea);
      nreq++; br_cnt++;
    end

    check("rdat_hs_pair", bus.b_rdat_valid && bus.b_rdat_ready, bus.rd_dat_valid && bus.rd_dat_ready);
    if (bus.rd_dat_valid) begin
      check("rdat_ctx", in_flight && !cur.is_wr && nreq == rbeat + 1, 1);
      ea = beat_addr(cur.addr, rbeat);
      check("rdat_data", bus.rd_dat, rd_pattern(ea));
      check("rdat_id", bus.rd_id, cur.id);
      check("rdat_last", bus.rd_last, rbeat == int'(cur.len));
      if (!bus.rd_dat_ready && stall_left > 0 && rbeat == stall_beat) begin
        stall_left--; stall_seen++;
      end
      if (bus.rd_dat_ready) begin
        rbeat++; rbeat_cnt++; rdat_on = 0;
        if (rq.size() > 0) void'(rq.pop_front());
        if (rbeat == int'(cur.len) + 1) begin
          in_flight = 0; last_wr = 0;
        end
      end
    end
  endtask

  task automatic drive();
    bus.wr_req_valid = wr_jobs.size() > 0;
    bus.wr_req_addr  = (wr_jobs.size() > 0) ? wr_jobs[0].addr : '0;
    bus.wr_req_len   = (wr_jobs.size() > 0) ? wr_jobs[0].len  : '0;
    bus.wr_req_id    = (wr_jobs.size() > 0) ? wr_jobs[0].id   : '0;
    bus.rd_req_valid = rd_jobs.size() > 0;
    bus.rd_req_addr  = (rd_jobs.size() > 0) ? rd_jobs[0].addr : '0;
    bus.rd_req_len   = (rd_jobs.size() > 0) ? rd_jobs[0].len  : '0;
    bus.rd_req_id    = (rd_jobs.size() > 0) ? rd_jobs[0].id   : '0;
    if (wbeats.size() > 0) begin
      if (!wdat_on) wdat_on = ($urandom % 4) != 0;
      bus.wr_dat = wbeats[0].data; bus.wr_strb = wbeats[0].strb; bus.wr_last = wbeats[0].last;
    end else begin
      wdat_on = 0;
    end
    bus.wr_dat_valid = wdat_on;
    bus.wr_rsp_ready = ($urandom % 3) != 0;
    if (in_flight && !cur.is_wr && stall_left > 0 && rbeat == stall_beat) bus.rd_dat_ready = 0;
    else bus.rd_dat_ready = rd_rand ? (($urandom % 4) != 0) : 1'b1;
    bus.b_wreq_ready = ($urandom % 3) != 0;
    bus.b_wdat_ready = ($urandom % 3) != 0;
    bus.b_rreq_ready = ($urandom % 3) != 0;
    if (wrsp_pend > 0) begin
      if (!wrsp_on) wrsp_on = $urandom % 2;
    end else wrsp_on = 0;
    bus.b_wrsp_valid = wrsp_on;
    if (rq.size() > 0) begin
      if (!rdat_on) rdat_on = $urandom % 2;
      bus.b_rdat = rd_pattern(rq[0]);
    end else rdat_on = 0;
    bus.b_rdat_valid = rdat_on;
  endtask

  initial begin
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) monitor();
      @(posedge clk);
      #1;
      if (rst_n) drive(); else idle_inputs();
    end
  end

  function automatic job_t mk(input bit w, input logic [31:0] a, input logic [7:0] l,
                              input logic [7:0] i, input bit b);
    job_t j;
    j.is_wr = w; j.addr = a; j.len = l; j.id = i; j.bad = b;
    return j;
  endfunction

  task automatic push_job(input job_t j);
    if (j.is_wr) wr_jobs.push_back(j); else rd_jobs.push_back(j);
  endtask

  task automatic reset_dut();
    @(posedge clk); #2;
    rst_n = 0; idle_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
  endtask

  task automatic wait_idle(input int unsigned budget);
    int unsigned n = 0;
    while ((wr_jobs.size() != 0 || rd_jobs.size() != 0 || in_flight) && n < budget) begin
      @(posedge clk); #2; n++;
    end
    check("idle_timeout", n < budget, 1);
    if (n >= budget) reset_dut();
    repeat (2) @(posedge clk);
    #2;
  endtask

  int unsigned s_bw, s_br, s_wr, s_rb;
  task automatic snap();
    s_bw = bw_cnt; s_br = br_cnt; s_wr = wrsp_cnt; s_rb = rbeat_cnt;
  endtask

  initial begin
    bit found;
    logic [31:0] a;
    rst_n = 0; rd_rand = 1; stall_seen = 0;
    bw_cnt = 0; br_cnt = 0; wrsp_cnt = 0; rbeat_cnt = 0;
    idle_inputs(); clear_model();
    repeat (3) @(posedge clk);
    #2;
    check("rst_vr", {bus.wr_req_ready, bus.rd_req_ready, bus.wr_dat_ready, bus.wr_rsp_valid, bus.rd_dat_valid,
                     bus.b_wreq_valid, bus.b_wdat_valid, bus.b_wrsp_ready, bus.b_rreq_valid, bus.b_rdat_ready}, 10'd0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #3 rst_n = 1;

    // Write burst, four beats
    snap(); push_job(mk(1, 32'h1000, 8'd3, 8'h05, 0)); wait_idle(2000);
    check("w4_breq", bw_cnt - s_bw, 4);
    check("w4_rsp", wrsp_cnt - s_wr, 1);

    // Single-beat read
    snap(); push_job(mk(0, 32'h2000, 8'd0, 8'h09, 0)); wait_idle(2000);
    check("r1_breq", br_cnt - s_br, 1);
    check("r1_beats", rbeat_cnt - s_rb, 1);

    // Simultaneous requests from reset: W, R, W
    reset_dut(); served.delete();
    push_job(mk(1, 32'h4000, 8'd1, 8'h11, 0));
    push_job(mk(0, 32'h5000, 8'd1, 8'h22, 0));
    push_job(mk(1, 32'h6000, 8'd0, 8'h33, 0));
    wait_idle(3000);
    check("rr_order", {served.size() == 3, served.size() > 2 ? {served[0], served[1], served[2]} : 3'b000}, 4'b1101);

    // Read with upstream stall on beat 1
    snap(); rd_rand = 0; stall_beat = 1; stall_left = 10; stall_seen = 0;
    push_job(mk(0, 32'h7000, 8'd2, 8'h44, 0)); wait_idle(2000);
    check("stall_cycles", stall_seen, 10);
    check("stall_breq", br_cnt - s_br, 3);
    check("stall_beats", rbeat_cnt - s_rb, 3);
    rd_rand = 1; stall_left = 0;

    // Early wr_last
    snap(); push_job(mk(1, 32'h8000, 8'd1, 8'h55, 1)); wait_idle(2000);
    check("badlast_err", err, 1);
    check("badlast_breq", bw_cnt - s_bw, 2);
    check("badlast_rsp", wrsp_cnt - s_wr, 1);

    // Reset during W_RSP of an eight-beat write
    push_job(mk(1, 32'h9000, 8'd7, 8'h66, 0));
    found = 0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(negedge clk); #1;
      if (in_flight && cur.is_wr && nrsp >= 3 && bus.b_wrsp_ready) found = 1;
    end
    check("wrsp_reached", found, 1);
    rst_n = 0; idle_inputs();
    #1;
    check("mid_rst_vr", {bus.wr_req_ready, bus.rd_req_ready, bus.wr_dat_ready, bus.wr_rsp_valid, bus.rd_dat_valid,
                         bus.b_wreq_valid, bus.b_wdat_valid, bus.b_wrsp_ready, bus.b_rreq_valid, bus.b_rdat_ready}, 10'd0);
    check("mid_rst_err", err, 0);
    check("mid_rst_busy", busy, 0);
    clear_model();
    repeat (2) @(posedge clk);
    #3 rst_n = 1;
    snap(); push_job(mk(0, 32'h3000, 8'd1, 8'h77, 0)); wait_idle(2000);
    check("post_rst_breq", br_cnt - s_br, 2);
    check("post_rst_beats", rbeat_cnt - s_rb, 2);
    check("post_rst_wrsp", wrsp_cnt - s_wr, 0);

    // Randomized batches, including a 256-beat burst and address wrap
    for (int b = 0; b < 6; b++) begin
      for (int j = 0; j < 6; j++) begin
        a = (($urandom % 4) == 0) ? (32'hFFFF_FF00 | ($urandom & 32'h0000_00FF)) : $urandom;
        if (b == 0 && j == 0) push_job(mk($urandom % 2, a, 8'd255, 8'($urandom), 0));
        else push_job(mk($urandom % 2, a, 8'($urandom % 9), 8'($urandom), ($urandom % 8) == 0));
      end
      wait_idle(8000);
    end

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end
endmodule
